// File: rtl/seg_pkg.sv
// Shared constants for 7-segment display blocks: active-low hex glyphs and
// blanking patterns.
package seg_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  localparam logic [6:0] SEG_OFF = 7'b111_1111;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  // Glyph bit order is {g,f,e,d,c,b,a}, 0 = segment lit.
  localparam logic [6:0] SEG_0 = 7'b100_0000;
  localparam logic [6:0] SEG_1 = 7'b111_1001;
  localparam logic [6:0] SEG_2 = 7'b010_0100;
  localparam logic [6:0] SEG_3 = 7'b011_0000;
  localparam logic [6:0] SEG_4 = 7'b001_1001;
  localparam logic [6:0] SEG_5 = 7'b001_0010;
  localparam logic [6:0] SEG_6 = 7'b000_0010;
  localparam logic [6:0] SEG_7 = 7'b111_1000;
  localparam logic [6:0] SEG_8 = 7'b000_0000;
  localparam logic [6:0] SEG_9 = 7'b001_0000;
  localparam logic [6:0] SEG_A = 7'b000_1000;
  localparam logic [6:0] SEG_B = 7'b000_0011;
  localparam logic [6:0] SEG_C = 7'b100_0110;
  localparam logic [6:0] SEG_D = 7'b010_0001;
  localparam logic [6:0] SEG_E = 7'b000_0110;
  localparam logic [6:0] SEG_F = 7'b000_1110;

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low 7-segment glyph decoder.
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_OFF;
    unique case (nibble_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
    endcase
  end

endmodule

// File: rtl/seg_scan_mux.sv
// 4-digit multiplexed 7-segment scan driver with frame-synchronous double buffering.
// Optional macro SEG_SCAN_LEADING_ZERO_BLANK_EN auto-blanks leading zero digits.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  blank,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int unsigned IdxW = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] PrescMax = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IdxW-1:0]  IdxLast  = IdxW'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] presc_q, presc_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [15:0]      shadow_val_q, shadow_val_d;
  logic [3:0]       shadow_blk_q, shadow_blk_d;
  logic [15:0]      disp_val_q, disp_val_d;
  logic [3:0]       disp_blk_q, disp_blk_d;
  logic             pending_q, pending_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;
  logic             frame_done_q, frame_done_d;

  logic             tick;
  logic             frame_end;
  logic [3:0]       nibble;
  logic [3:0]       blk_eff;
  logic [6:0]       seg_dec;

  assign tick      = (presc_q == PrescMax);
  assign frame_end = tick && (idx_q == IdxLast);

  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
    idx_d   = tick ? idx_q + 1'b1 : idx_q;
  end

  // Display only swaps at the frame boundary so a frame never mixes old and new digits.
  always_comb begin
    shadow_val_d = shadow_val_q;
    shadow_blk_d = shadow_blk_q;
    disp_val_d   = disp_val_q;
    disp_blk_d   = disp_blk_q;
    pending_d    = pending_q;
    if (frame_end) begin
      if (load) begin
        disp_val_d = value;
        disp_blk_d = blank;
      end else if (pending_q) begin
        disp_val_d = shadow_val_q;
        disp_blk_d = shadow_blk_q;
      end
      pending_d = 1'b0;
    end else if (load) begin
      shadow_val_d = value;
      shadow_blk_d = blank;
      pending_d    = 1'b1;
    end
  end

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
  logic lz3, lz2, lz1;
  assign lz3     = (disp_val_q[15:12] == 4'h0);
  assign lz2     = lz3 && (disp_val_q[11:8] == 4'h0);
  assign lz1     = lz2 && (disp_val_q[7:4] == 4'h0);
  assign blk_eff = disp_blk_q | {lz3, lz2, lz1, 1'b0};
`else
  assign blk_eff = disp_blk_q;
`endif

  assign nibble = disp_val_q[{idx_q, 2'b00} +: 4];

  hex_to_seg u_hex_to_seg (
    .nibble_i (nibble),
    .seg_o    (seg_dec)
  );

  always_comb begin
    seg_d        = seg_dec;
    an_d         = ~(4'b0001 << idx_q);
    frame_done_d = frame_end;
    if (blk_eff[idx_q]) begin
      seg_d = SEG_OFF;
      an_d  = AN_OFF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q      <= '0;
      idx_q        <= '0;
      shadow_val_q <= '0;
      shadow_blk_q <= '0;
      disp_val_q   <= '0;
      disp_blk_q   <= '0;
      pending_q    <= 1'b0;
      seg_q        <= SEG_OFF;
      an_q         <= AN_OFF;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      shadow_val_q <= shadow_val_d;
      shadow_blk_q <= shadow_blk_d;
      disp_val_q   <= disp_val_d;
      disp_blk_q   <= disp_blk_d;
      pending_q    <= pending_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
- Time-multiplexed 4-digit 7-segment scan driver.
- Sits between the XOR NN result logic and the board segment/anode pins. It replaces the static single-digit drive with a full 4-digit hex readout.
- Accepts a 16-bit value (4 hex nibbles) plus a per-digit blank mask through a load strobe.
- Double-buffers the value and scans digits at a fixed refresh rate, so updates never tear mid-frame.

Parameters:
- REFRESH_DIV, 50000, clk cycles per digit slot. Must be ≥ 2. 50000 at 50 MHz gives 1 kHz per digit and 250 Hz per frame.
- CNT_W, 16, width of the prescaler counter. Must satisfy 2^CNT_W > REFRESH_DIV-1.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- load  input  1  one-cycle strobe; captures value and blank into the shadow register
- value  input  16  digit3 = [15:12] … digit0 = [3:0]
- blank  input  4  per-digit force-off (1 = digit dark); captured together with value
- seg  output  7  registered segment pattern {g,f,e,d,c,b,a}, active-low
- an  output  4  registered anode enables, active-low; an[0] is the rightmost digit
- frame_done  output  1  one-cycle pulse when the digit 3 slot ends

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst; all state changes only on posedge clk.
- Reset values:
  - seg = 7'b111_1111, an = 4'b1111, frame_done = 0.
  - Prescaler = 0, digit index = 0.
  - Shadow value/blank = 0/0, display value/blank = 0/0, pending = 0.
  - rst held mid-scan: the same values apply on the next edge, and no frame_done pulse is emitted.
- Prescaler:
  - Counts 0 … REFRESH_DIV-1, then wraps to 0.
  - tick = (prescaler == REFRESH_DIV-1).
- Digit index (2 bits): advances on tick; 3 → 0 wraps.
- Frame boundary (tick with index == 3):
  - frame_done = 1 on the next cycle.
  - The display register loads the shadow register if pending = 1, then pending clears.
- Load:
  - On load, the shadow register takes value/blank and pending is set.
  - A later load before the frame boundary overwrites the shadow; last write wins.
  - Load in the same cycle as the frame boundary bypasses the shadow: the incoming value/blank go straight to the display register and pending ends at 0.
- Output stage (registered, 1-cycle latency from index/display state):
  - an = ~(4'b0001 << index), except an = 4'b1111 when the blank bit of the current digit is set.
  - seg = hex decode of the selected nibble. seg = 7'b111_1111 whenever the digit is blanked.
- First output after reset release: an = 4'b1110, seg = 7'b100_0000 (digit 0 showing "0").
- Hex encoding ({g..a}, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- No ghosting guarantee beyond a single-cycle transition; an and seg change on the same edge.

Optional Feature:
- Macro: SEG_SCAN_LEADING_ZERO_BLANK_EN.
- With the macro defined: digit k (k = 3 down to 1) is additionally blanked when its nibble and all higher nibbles of the display value are 0. Digit 0 is never auto-blanked. The blank input is ORed in.
- Without the macro: only the explicit blank mask blanks digits.

Decomposition:
- Shared package (seg_pkg): the 16 segment-pattern constants, SEG_OFF = 7'b111_1111, AN_OFF = 4'b1111, digit-count constant 4.
- Sub-module hex_to_seg: combinational 4-bit → 7-bit decoder. It is reused by later display blocks.
- Top: prescaler, index counter, shadow/display registers, output registers.

Test Plan:
All scenarios use REFRESH_DIV = 4.
1. Reset release, no load → digit 0 slot shows an = 1110, seg = 1000000. Then each digit in turn shows "0". frame_done pulses every 16 cycles.
2. load value = 16'h1A2F, blank = 0 mid-frame → the old value holds until the frame boundary. The next frame shows digit0 F = 0001110, digit1 2 = 0100100, digit2 A = 0001000, digit3 1 = 1111001.
3. Two loads in one frame (16'h1111 then 16'h2222) → only 2222 appears next frame; 1111 is never displayed.
4. load coincident with the boundary tick, value = 16'h00C0 → C is visible on digit1 in the very next frame; pending ends at 0.
5. blank = 4'b1010 with value = 16'h8888 → digits 1 and 3 show an = 1111, seg = 1111111. Digits 0 and 2 show 0000000.
6. rst asserted for 1 cycle during the digit 2 slot → the next cycle gives an = 1111, seg = 1111111. Scan then restarts at digit 0 with the display value = 0 and no frame_done pulse.
   - With SEG_SCAN_LEADING_ZERO_BLANK_EN: value = 16'h0005 → digits 3..1 dark, digit 0 = 0010010.
